uart_tx_fifo: RTL

Buffered UART transmitter: accepts bytes on a valid/ready stream, queues them in an internal FIFO and serialises them as 8N1 frames, LSB first, on a single line. It is the transmit end of the serial link whose receive side samples start, data and stop bits at a fixed bit period. The block sits between the SoC's peripheral bus adapter and the `uart_tx` pad.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte stream -> FIFO -> serial line, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 208,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          rdy_q;
  logic [AW:0]   wr_q, rd_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       push, pop, empty, bit_end;
  logic [7:0] head;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign fifo_level = wr_q - rd_q;
  assign empty      = (wr_q == rd_q);
  assign head       = mem_q[rd_q[AW-1:0]];
  assign s_tready   = rdy_q && (fifo_level != (AW+1)'(FIFO_DEPTH));
  assign push       = s_tvalid && s_tready;
  assign bit_end    = (baud_q == BAUD_LAST);
  assign uart_tx    = tx_q;
  assign busy       = (state_q != S_IDLE) || (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: if (!empty) pop = 1'b1;
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop always launches a fresh frame, from IDLE or straight out of STOP.
    if (pop) begin
      shift_d = head;
      bit_d   = '0;
      baud_d  = '0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  // The line register follows the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rdy_q   <= 1'b1;
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= s_tdata;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
